kernel_cache_loader: RTL and testbench

KERNEL_CACHE_LOADER -- requirements
Module: kernel_cache_loader

---
 rtl/kcl_pkg.sv | 15 +
 rtl/kcl_row_packer.sv | 49 ++++
 rtl/kernel_cache_loader.sv | 105 ++++++++++
 tb/tb_kernel_cache_loader.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kcl_pkg.sv
// kcl_pkg: shared kernel-cache geometry and loader state encoding.
// ROWS and ROW_W are also consumed by the ALU and its bench.
package kcl_pkg;
  localparam int ROWS        = 3;
  localparam int ROW_W       = 24;
  localparam int NIB_PER_ROW = 6;
  localparam int NIBBLES     = ROWS * NIB_PER_ROW;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;
endpackage

// File: rtl/kcl_row_packer.sv
// kcl_row_packer: row/nibble counters that drop each fetched nibble into the
// kernel rows, MSB-first, and flag the final nibble of a load.
module kcl_row_packer
  import kcl_pkg::*;
#(
  parameter int BUS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [BUS-1:0]   wr_data,
  output logic [ROW_W-1:0] rows [0:ROWS-1],
  output logic             last
);
  localparam int ROW_CW = $clog2(ROWS);
  localparam int COL_CW = $clog2(NIB_PER_ROW);

  logic [ROW_CW-1:0] row_q;
  logic [COL_CW-1:0] col_q;

  assign last = (row_q == ROW_CW'(ROWS - 1)) && (col_q == COL_CW'(NIB_PER_ROW - 1));

  // NOTE: the rows feed the ALU combinationally, so they are reset like any
  // other output register rather than left as uninitialised storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
      for (int r = 0; r < ROWS; r++) rows[r] <= '0;
    end else if (clear) begin
      row_q <= '0;
      col_q <= '0;
    end else if (wr_en) begin
      // NOTE: non-blocking assignments keep the write slot and the counter
      // advance both based on the pre-edge counter values.
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < NIB_PER_ROW; c++)
          if (int'(row_q) == r && int'(col_q) == c)
            rows[r][ROW_W-1-BUS*c -: BUS] <= wr_data;
      if (col_q == COL_CW'(NIB_PER_ROW - 1)) begin
        col_q <= '0;
        row_q <= row_q + ROW_CW'(1);
      end else begin
        col_q <= col_q + COL_CW'(1);
      end
    end
  end
endmodule

// File: rtl/kernel_cache_loader.sv
// kernel_cache_loader: fetches an 18-nibble kernel from memory into the ALU cache.
// Define KCL_CHECKSUM_EN to add a modulo-256 checksum output of each completed load.
module kernel_cache_loader
  import kcl_pkg::*;
#(
  parameter int BUS    = 4,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [BUS-1:0]    mem_rdata,
  output logic [ROW_W-1:0]  cache [0:ROWS-1],
  output logic              cache_valid,
  output logic              busy,
  output logic              done
`ifdef KCL_CHECKSUM_EN
  ,
  output logic [7:0]        checksum
`endif
);
  state_t state;
  logic   accept;
  logic   wr_en;
  logic   last;

  // Flush outranks both a new request and a returning nibble.
  assign accept = (state == IDLE) && start && !flush;
  assign wr_en  = (state == WAIT) && mem_ack && !flush;

  kcl_row_packer #(.BUS(BUS)) u_packer (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .wr_en   (wr_en),
    .wr_data (mem_rdata),
    .rows    (cache),
    .last    (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      cache_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else if (flush) begin
      state       <= IDLE;
      mem_req     <= 1'b0;
      cache_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state       <= REQ;
          mem_addr    <= base_addr;
          mem_req     <= 1'b1;
          busy        <= 1'b1;
          cache_valid <= 1'b0;
        end
        REQ: state <= WAIT;
        WAIT: if (mem_ack) begin
          if (last) begin
            state       <= DONE;
            mem_req     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            cache_valid <= 1'b1;
          end else begin
            state    <= REQ;
            mem_addr <= mem_addr + ADDR_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef KCL_CHECKSUM_EN
  logic [7:0] sum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q    <= '0;
      checksum <= '0;
    end else if (accept) begin
      sum_q <= '0;
    end else if (wr_en) begin
      sum_q <= sum_q + 8'(mem_rdata);
      if (last) checksum <= sum_q + 8'(mem_rdata);
    end
  end
`endif
endmodule

// File: tb/tb_kernel_cache_loader.sv
// tb_kernel_cache_loader: randomized loads against a nibble-memory reference
// model; address and completion scoreboards are checked by negedge monitors.
module tb_kernel_cache_loader;
  import kcl_pkg::*;

  localparam int BUS    = 4;
  localparam int ADDR_W = 8;

  logic              clk;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              flush;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [BUS-1:0]    mem_rdata;
  logic [ROW_W-1:0]  cache [0:ROWS-1];
  logic              cache_valid;
  logic              busy;
  logic              done;
`ifdef KCL_CHECKSUM_EN
  logic [7:0]        checksum;
`endif

  kernel_cache_loader #(.BUS(BUS), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .flush       (flush),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .cache       (cache),
    .cache_valid (cache_valid),
    .busy        (busy),
    .done        (done)
`ifdef KCL_CHECKSUM_EN
    ,
    .checksum    (checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [ROWS-1:0][ROW_W-1:0] rows;
    logic [7:0]                 csum;
  } exp_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acks_seen = 0;
  int done_count = 0;
  int done_cyc = 0;
  int start_edge = 0;
  int max_delay = 0;

  logic [BUS-1:0]             mem [0:255];
  logic [ROWS-1:0][ROW_W-1:0] model;
  logic [ADDR_W-1:0]          exp_addr [$];
  exp_t                       exp_done [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Memory responder: acks every request after 1 + random(0..max_delay) cycles.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      if (mem_req && !rst) begin
        @(posedge clk); #1;
        repeat ($urandom_range(max_delay, 0)) begin
          @(posedge clk); #1;
        end
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr];
        @(posedge clk); #1;
        mem_ack   = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
  end

  // Monitor: every accepted nibble must carry the next expected address.
  initial forever begin
    @(negedge clk);
    if (!rst && mem_req && mem_ack && !flush) begin
      acks_seen++;
      if (exp_addr.size() == 0) check("unexpected_ack", 1, 0);
      else check("mem_addr", mem_addr, exp_addr.pop_front());
    end
  end

  // Monitor: every done pulse must match the next completed-load prediction.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst && done) begin
      done_count++;
      done_cyc = cyc;
      if (exp_done.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = exp_done.pop_front();
        for (int r = 0; r < ROWS; r++) check($sformatf("row%0d", r), cache[r], e.rows[r]);
        check("valid_at_done", cache_valid, 1);
`ifdef KCL_CHECKSUM_EN
        check("checksum", checksum, e.csum);
`endif
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Reference model: nibble k of the load lands in row k/6, position k%6 from the MSB.
  task automatic start_load(input logic [ADDR_W-1:0] base, input int n_written, input bit completes);
    exp_t e;
    int   sum;
    sum = 0;
    for (int k = 0; k < NIBBLES; k++) begin
      logic [ADDR_W-1:0] a;
      a = base + ADDR_W'(k);
      exp_addr.push_back(a);
      if (k < n_written) begin
        model[k / NIB_PER_ROW][ROW_W-1-BUS*(k % NIB_PER_ROW) -: BUS] = mem[a];
        sum += int'(mem[a]);
      end
    end
    e.rows = model;
    e.csum = 8'(sum);
    if (completes) exp_done.push_back(e);
    start      = 1'b1;
    base_addr  = base;
    start_edge = cyc + 1;
    tick(1);
    start      = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c0;
    c0 = done_count;
    for (int i = 0; i < budget && done_count == c0; i++) tick(1);
    check("done_within_budget", done_count != c0, 1);
  endtask

  task automatic wait_acks(input int target, input int budget);
    for (int i = 0; i < budget && acks_seen < target; i++) tick(1);
    check("acks_within_budget", acks_seen >= target, 1);
  endtask

  task automatic check_all_zero(input string tag);
    for (int r = 0; r < ROWS; r++) check($sformatf("%s_row%0d", tag, r), cache[r], 0);
    check({tag, "_valid"}, cache_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_mem_req"}, mem_req, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
`ifdef KCL_CHECKSUM_EN
    check({tag, "_checksum"}, checksum, 0);
`endif
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < 256; i++) mem[i] = BUS'($urandom);
  endtask

  initial begin
    int a0;
    int d0;
    logic [ADDR_W-1:0] b;
    rst = 1'b0; start = 1'b0; flush = 1'b0; base_addr = '0;
    model = '0;
    randomize_mem();

    // Reset takes effect without a clock edge.
    #2 rst = 1'b1;
    #1 check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    tick(2);

    // Basic load with single-cycle acks: fixed data, fixed rows, minimum latency.
    for (int i = 0; i < NIBBLES; i++) mem[8'h10 + i] = BUS'(i % 16);
    max_delay = 0;
    start_load(8'h10, NIBBLES, 1);
    check("busy_during_load", busy, 1);
    check("valid_cleared_on_start", cache_valid, 0);
    wait_done(100);
    check("latency_edges", done_cyc - start_edge, 2 * NIBBLES);
    check("basic_row0", cache[0], 24'h012345);
    check("basic_row1", cache[1], 24'h6789AB);
    check("basic_row2", cache[2], 24'hCDEF01);
    check("basic_valid", cache_valid, 1);
    check("basic_done_low", done, 0);
    check("basic_done_count", done_count, 1);
`ifdef KCL_CHECKSUM_EN
    check("basic_checksum", checksum, 8'h79);
`endif

    // Address wrap with stalls.
    randomize_mem();
    max_delay = 3;
    start_load(8'hF8, NIBBLES, 1);
    wait_done(300);
    check("wrap_addr_drained", exp_addr.size(), 0);

    // A second start while busy must neither restart nor add a done.
    randomize_mem();
    d0 = done_count;
    b  = ADDR_W'($urandom);
    start_load(b, NIBBLES, 1);
    tick(5);
    start = 1'b1; base_addr = b + 8'h40;
    tick(1);
    start = 1'b0;
    check("ignored_start_busy", busy, 1);
    wait_done(300);
    tick(40);
    check("ignored_start_one_done", done_count, d0 + 1);

    // Flush after nibble 7: partial rows kept, no done, valid cleared.
    randomize_mem();
    d0 = done_count;
    a0 = acks_seen;
    start_load(ADDR_W'($urandom), 8, 0);
    wait_acks(a0 + 8, 200);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    exp_addr.delete();
    check("flush_busy", busy, 0);
    check("flush_mem_req", mem_req, 0);
    check("flush_valid", cache_valid, 0);
    for (int r = 0; r < ROWS; r++) check($sformatf("flush_row%0d", r), cache[r], model[r]);
    tick(10);
    check("flush_no_done", done_count, d0);
    check("flush_nibbles", acks_seen, a0 + 8);

    // Reset at nibble 10, then a clean load.
    randomize_mem();
    a0 = acks_seen;
    start_load(ADDR_W'($urandom), 10, 0);
    wait_acks(a0 + 10, 200);
    rst = 1'b1;
    #1 check_all_zero("midload_reset");
    exp_addr.delete();
    model = '0;
    tick(2);
    rst = 1'b0;
    tick(1);
    check("idle_after_reset", busy, 0);
    tick(6);
    start_load(ADDR_W'($urandom), NIBBLES, 1);
    wait_done(300);

    // Randomized loads with mixed stall depth.
    for (int n = 0; n < 5; n++) begin
      randomize_mem();
      max_delay = $urandom_range(3, 0);
      start_load(ADDR_W'($urandom), NIBBLES, 1);
      wait_done(300);
      tick($urandom_range(3, 0));
    end
    tick(8);
    check("scoreboard_drained", exp_done.size() + exp_addr.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end
endmodule
